// File: rtl/mux_arb_2x1.sv
// ---------------------------------------------------------------------------
// mux_arb_2x1
//
// Two-requester arbiter feeding a registered 2:1 mux output with a
// valid/ready style downstream port.
//
// A winner is chosen only while the FSM is IDLE. The winner's data is
// captured into y, y_valid is raised and a one-cycle grant pulse tells the
// requester its data was taken. The block then sits in BUSY until the
// downstream accepts y, counts the completed transfer and returns to IDLE.
//
// Handshake: a transfer completes on a rising clk edge where y_valid=1 and
// y_ready=1. While y_valid=1, y is held stable. y_ready has no effect while
// y_valid=0. Requesters must hold data stable while req is high and must
// drop or update req/data on the edge after their grant; a request still
// high when the block is next IDLE is taken as a new request.
//
// Optional feature macro: MUX_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, A always beats B (sel_last still tracked)
//   undefined -> round-robin using sel_last
//
// Parameters:
//   N   data width of each source and of y
//   CW  width of the saturating transfer counter
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req_a/req_b  request from requester A/B
//   data_a/data_b requester data
//   gnt_a/gnt_b  registered one-cycle capture pulses
//   y            registered shared output
//   y_valid      y holds a transfer not yet accepted
//   y_ready      downstream accepts y
//   sel_last     last winner (1 = A, 0 = B)
//   xfer_cnt     saturating count of completed transfers
//   fsm_state_o  current FSM state (0 = IDLE, 1 = BUSY), debug visibility
// ---------------------------------------------------------------------------
module mux_arb_2x1 #(
    parameter int N  = 2,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic [N-1:0]  data_a,
    input  logic          req_b,
    input  logic [N-1:0]  data_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic [N-1:0]  y,
    output logic          y_valid,
    input  logic          y_ready,
    output logic          sel_last,
    output logic [CW-1:0] xfer_cnt,
    output logic          fsm_state_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [0:0]    state_q,    state_d;
    logic [N-1:0]  y_q,        y_d;
    logic          y_valid_q,  y_valid_d;
    logic          gnt_a_q,    gnt_a_d;
    logic          gnt_b_q,    gnt_b_d;
    logic          sel_last_q, sel_last_d;
    logic [CW-1:0] xfer_cnt_q, xfer_cnt_d;

    logic win_a;
    logic win_b;

    // Winner selection. B can only win when A does not, so the two grants
    // are mutually exclusive by construction.
`ifdef MUX_ARB_FIXED_PRIO_EN
    assign win_a = req_a;
`else
    // With both requesting, the one that did not win last time goes.
    // sel_last resets to 0 (B), so the first contested grant goes to A.
    assign win_a = req_a && (!req_b || !sel_last_q);
`endif
    assign win_b = req_b && !win_a;

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        sel_last_d = sel_last_q;
        xfer_cnt_d = xfer_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_a) begin
                    y_d        = data_a;
                    y_valid_d  = 1'b1;
                    gnt_a_d    = 1'b1;
                    sel_last_d = 1'b1;
                    state_d    = BUSY;
                end else if (win_b) begin
                    y_d        = data_b;
                    y_valid_d  = 1'b1;
                    gnt_b_d    = 1'b1;
                    sel_last_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                // Requests are not looked at here; y stays put until taken.
                if (y_valid_q && y_ready) begin
                    y_valid_d = 1'b0;
                    if (xfer_cnt_q != CNT_MAX) begin
                        xfer_cnt_d = xfer_cnt_q + CNT_ONE;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            sel_last_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            sel_last_q <= sel_last_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign gnt_a       = gnt_a_q;
    assign gnt_b       = gnt_b_q;
    assign y           = y_q;
    assign y_valid     = y_valid_q;
    assign sel_last    = sel_last_q;
    assign xfer_cnt    = xfer_cnt_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_mux_arb_2x1.sv
module tb_mux_arb_2x1;

  localparam int N  = 2;
  localparam int CW = 8;
  localparam int W  = N + 1;

`ifdef MUX_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          req_a;
  logic [N-1:0]  data_a;
  logic          req_b;
  logic [N-1:0]  data_b;
  logic          y_ready;

  logic          gnt_a, gnt_b, y_valid, sel_last, fsm_state;
  logic [N-1:0]  y;
  logic [CW-1:0] xfer_cnt;

  logic          s_gnt_a, s_gnt_b, s_y_valid, s_sel_last, s_fsm_state;
  logic [N-1:0]  s_y;
  logic [1:0]    s_xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  mux_arb_2x1 #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .y(y), .y_valid(y_valid), .y_ready(y_ready),
    .sel_last(sel_last), .xfer_cnt(xfer_cnt),
    .fsm_state_o(fsm_state)
  );

  mux_arb_2x1 #(.N(N), .CW(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .gnt_a(s_gnt_a), .gnt_b(s_gnt_b),
    .y(s_y), .y_valid(s_y_valid), .y_ready(y_ready),
    .sel_last(s_sel_last), .xfer_cnt(s_xfer_cnt),
    .fsm_state_o(s_fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string tag);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    check((gnt_a & gnt_b) === 1'b0, "gnt_excl");
    if (gnt_a || gnt_b) begin
      if (exp_q.size() == 0) begin
        check({gnt_b, gnt_a} === 2'b00, "unexpected_gnt");
      end else begin
        e = exp_q.pop_front();
        check(gnt_b === e[N], "gnt_b_sel");
        check(gnt_a === ~e[N], "gnt_a_sel");
        check(y === e[N-1:0], "gnt_y");
        check(y_valid === 1'b1, "gnt_y_valid");
      end
    end
  endtask

  task automatic push_exp(input logic is_b, input logic [N-1:0] val);
    exp_q.push_back({is_b, val});
  endtask

  initial begin
    rst     = 1'b1;
    req_a   = 1'b0;
    req_b   = 1'b0;
    data_a  = '0;
    data_b  = '0;
    y_ready = 1'b0;

    tick();
    check(y === 2'd0, "rst_y");
    check(y_valid === 1'b0, "rst_y_valid");
    check(xfer_cnt === 8'd0, "rst_cnt");
    check(sel_last === 1'b0, "rst_sel_last");
    check(fsm_state === 1'b0, "rst_state");
    check({gnt_a, gnt_b} === 2'b00, "rst_gnt");
    rst = 1'b0;

    y_ready = 1'b1;
    tick();
    tick();
    check(y_valid === 1'b0, "idle_hold_valid");
    check(xfer_cnt === 8'd0, "idle_hold_cnt");

    req_a  = 1'b1;
    data_a = 2'd2;
    push_exp(1'b0, 2'd2);
    tick();
    check(gnt_a === 1'b1, "single_gnt_a");
    check(fsm_state === 1'b1, "single_busy");
    check(sel_last === 1'b1, "single_sel_last");
    req_a = 1'b0;
    tick();
    check(y_valid === 1'b0, "single_done_valid");
    check(xfer_cnt === 8'd1, "single_done_cnt");
    check(gnt_a === 1'b0, "single_done_gnt");
    check(fsm_state === 1'b0, "single_done_idle");

    y_ready = 1'b0;
    req_a   = 1'b1;
    data_a  = 2'd3;
    push_exp(1'b0, 2'd3);
    tick();
    req_a = 1'b0;
    check(y === 2'd3, "pre_rst_y");
    check(fsm_state === 1'b1, "pre_rst_state");
    #2 rst = 1'b1;
    #1;
    check(y === 2'd0, "async_rst_y");
    check(y_valid === 1'b0, "async_rst_valid");
    check(xfer_cnt === 8'd0, "async_rst_cnt");
    check(fsm_state === 1'b0, "async_rst_state");
    check(sel_last === 1'b0, "async_rst_sel_last");
    check(s_xfer_cnt === 2'd0, "async_rst_sat_cnt");
    tick();
    rst = 1'b0;

    req_a   = 1'b1;
    data_a  = 2'd1;
    req_b   = 1'b1;
    data_b  = 2'd2;
    y_ready = 1'b1;
    push_exp(1'b0, 2'd1);
    push_exp(FIXED ? 1'b0 : 1'b1, FIXED ? 2'd1 : 2'd2);
    push_exp(1'b0, 2'd1);
    push_exp(FIXED ? 1'b0 : 1'b1, FIXED ? 2'd1 : 2'd2);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check(y_valid === ((i % 2) == 1), "both_valid_pattern");
      check(!(FIXED && gnt_b === 1'b1), "both_no_gnt_b_fixed");
    end
    check(xfer_cnt === 8'd4, "both_cnt");
    check(s_xfer_cnt === 2'd3, "both_sat_cnt");
    check(sel_last === FIXED, "both_sel_last");
    check(exp_q.size() == 0, "both_queue_drained");
    req_a = 1'b0;
    req_b = 1'b0;

    y_ready = 1'b0;
    req_a   = 1'b1;
    data_a  = 2'd1;
    push_exp(1'b0, 2'd1);
    tick();
    data_a = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check(y === 2'd1, "stall_y");
      check(y_valid === 1'b1, "stall_valid");
      check({gnt_a, gnt_b} === 2'b00, "stall_no_gnt");
    end
    check(xfer_cnt === 8'd4, "stall_cnt");
    req_a   = 1'b0;
    y_ready = 1'b1;
    tick();
    check(xfer_cnt === 8'd5, "stall_release_cnt");
    check(y_valid === 1'b0, "stall_release_valid");
    check(s_xfer_cnt === 2'd3, "stall_sat_cnt");
    tick();
    check(xfer_cnt === 8'd5, "idle_ready_ignored");

    req_a  = 1'b1;
    data_a = 2'd1;
    req_b  = 1'b1;
    data_b = 2'd2;
    push_exp(FIXED ? 1'b0 : 1'b1, FIXED ? 2'd1 : 2'd2);
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    check(sel_last === FIXED, "rr_sel_last");
    tick();
    check(xfer_cnt === 8'd6, "final_cnt");
    check(s_xfer_cnt === 2'd3, "final_sat_cnt");
    check(exp_q.size() == 0, "final_queue_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arb_2x1.md
MUX_ARB_2X1 -- requirements
Module: mux_arb_2x1

Interface
REQ-001 The module SHALL have parameter N, default 2, the data width of each source and of the output.
REQ-002 The module SHALL have parameter CW, default 8, the width of the transfer counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_a  input  1  requester A has data pending on data_a.
REQ-006 data_a  input  N  requester A data, held stable while req_a=1.
REQ-007 req_b  input  1  requester B has data pending on data_b.
REQ-008 data_b  input  N  requester B data, held stable while req_b=1.
REQ-009 gnt_a  output  1  one-cycle registered pulse: data_a was captured.
REQ-010 gnt_b  output  1  one-cycle registered pulse: data_b was captured.
REQ-011 y  output  N  registered shared output (2:1 mux result).
REQ-012 y_valid  output  1  y holds a transfer not yet accepted.
REQ-013 y_ready  input  1  downstream accepts y when y_valid=1.
REQ-014 sel_last  output  1  last winner: 1=A, 0=B.
REQ-015 xfer_cnt  output  CW  count of completed transfers (y_valid and y_ready both 1).

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-017 In IDLE with no request asserted, all state SHALL hold, and gnt_a and gnt_b SHALL be 0.
REQ-018 In IDLE with a winner W chosen, the next edge SHALL load y with data_W, set y_valid=1, pulse gnt_W=1 for exactly one cycle, set sel_last to W, and enter BUSY.
REQ-019 Arbitration in IDLE SHALL be round-robin: a lone request wins; with both asserted, the requester not equal to sel_last wins.
REQ-020 In BUSY, requests SHALL NOT be sampled, y SHALL be held stable, and gnt_a and gnt_b SHALL be 0 after the pulse cycle.
REQ-021 In BUSY with y_ready=1, the next edge SHALL clear y_valid, increment xfer_cnt, and return to IDLE.
REQ-022 In BUSY with y_ready=0, the block SHALL stay in BUSY indefinitely, with y and y_valid held.
REQ-023 y_ready SHALL be ignored while y_valid=0.
REQ-024 Requesters SHALL deassert or update req/data on the edge following gnt; a request held after gnt is treated as a new request.
REQ-025 Minimum spacing between grants SHALL be 2 cycles, giving a peak throughput of one transfer per 2 cycles.
REQ-026 xfer_cnt SHALL saturate at 2^CW-1 and never wrap.
REQ-027 gnt_a and gnt_b SHALL never both be 1 in the same cycle.

Reset
REQ-028 Asserting rst SHALL immediately force: state=IDLE, y=0, y_valid=0, gnt_a=0, gnt_b=0, sel_last=0, xfer_cnt=0.
REQ-029 Reset asserted mid-transfer (BUSY) SHALL discard the pending y with no count increment.
REQ-030 After reset, the first arbitration with both requests asserted SHALL grant A.

Configuration
REQ-031 When macro MUX_ARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority, with A always winning over B, while sel_last is still updated.
REQ-032 When MUX_ARB_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-019.

Verification
REQ-033 rst pulsed during BUSY with y=3 -> outputs immediately y=0, y_valid=0, xfer_cnt=0, state IDLE.
REQ-034 req_a=1, data_a=2 only, y_ready=1 -> next edge: y=2, y_valid=1, gnt_a=1; following edge: y_valid=0, xfer_cnt=1.
REQ-035 Both requests held, data_a=1, data_b=2, y_ready=1 -> y sequence 1,2,1,2 with alternating gnt pulses; xfer_cnt=4 after 8 cycles.
REQ-036 Grant A with y=1, y_ready=0 for 5 cycles, data_a changed to 3 -> y stays 1, y_valid stays 1, no gnt; after y_ready=1, xfer_cnt increments once.
REQ-037 With MUX_ARB_FIXED_PRIO_EN defined, both requests held -> only gnt_a pulses, and gnt_b never fires.
REQ-038 With CW=2, perform 5 transfers -> xfer_cnt=3, saturated.
